gin_xbus_ctrl: RTL
==================

# gin_xbus_ctrl

Controller for the global input network (GIN) X-bus. It loads the per-column ID registers that the column multicast controllers (MCCs) compare against the bus tag. It then accepts tagged packets from the upstream buffer and presents each one on the X-bus. A packet is issued only when every column reports ready. The block sits between the GLB read port and the X-bus, one instance per X-bus.

## Interface
Parameters:
- DATA_WIDTH, 64, packet payload width
- COL_TAG_WIDTH, 4, width of column tags and IDs
- NUM_OF_COLS, 14, number of MCC columns on the bus

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cfg_start  in  1  request to (re)load column IDs
- cfg_valid  in  1  cfg_id is valid this cycle
- cfg_id  in  COL_TAG_WIDTH  next column ID, column 0 first
- cfg_loaded  out  1  level; all IDs loaded, block is in RUN
- col_id  out  COL_TAG_WIDTH x [0:NUM_OF_COLS-1]  registered column IDs to the X-bus
- src_data  in  DATA_WIDTH  upstream payload
- src_tag  in  COL_TAG_WIDTH  upstream destination column tag
- src_valid  in  1  upstream packet valid
- src_ready  out  1  block accepts the packet this cycle
- bus_data  out  DATA_WIDTH  X-bus data_in
- bus_tag  out  COL_TAG_WIDTH  X-bus col_tag
- bus_enable  out  1  X-bus enable_in
- bus_ready  in  [0:NUM_OF_COLS]-1 bits, one per column  per-column ready_out from the X-bus

## Operation
The block uses a three-state FSM: IDLE, CFG, RUN.

- **IDLE** is the reset state.
  - src_ready=0 and cfg_loaded=0.
  - cfg_start=1 moves the FSM to CFG.
- **CFG** loads the column IDs.
  - Entering CFG clears the 4-bit-minimum index counter idx to 0 and clears cfg_loaded.
  - Each cycle with cfg_valid=1 writes cfg_id to col_id[idx] and increments idx.
  - The write with idx=NUM_OF_COLS-1 moves the FSM to RUN and sets cfg_loaded=1 the next cycle.
  - cfg_valid=0 cycles are stalls; the FSM stays in CFG indefinitely.
  - cfg_start while in CFG restarts loading at idx=0.
- **RUN** transfers packets.
  - A single holding register (hold_valid, hold_data, hold_tag) drives bus_data and bus_tag directly.
  - all_ready = AND of bus_ready[0..NUM_OF_COLS-1].
  - bus_enable = hold_valid & all_ready (combinational). bus_enable=1 is a "fire".
  - src_ready = (state==RUN) & (~hold_valid | all_ready) & ~cfg_start.
  - When src_valid & src_ready: load the holding register and set hold_valid=1.
  - When a fire occurs with no new accept: clear hold_valid.
  - When a fire and an accept occur in the same cycle: replace the contents and keep hold_valid=1.
- **Reconfiguration from RUN:**
  - cfg_start with hold_valid=0 moves the FSM to CFG next cycle.
  - cfg_start with hold_valid=1 blocks new accepts. The held packet drains first, and the FSM enters CFG on the cycle after the fire.
- **Holding register with no tag match:** if no col_id matches hold_tag, the MCCs still drive ready, so the packet fires and is dropped. This is not an error.
- col_id is stable outside CFG; it changes only on CFG writes.

## Timing
Reset values (reset=0 at a clk edge):
- state=IDLE, idx=0, hold_valid=0, hold_data=0, hold_tag=0.
- All col_id=0, cfg_loaded=0, src_ready=0, bus_enable=0, bus_data=0, bus_tag=0.

Reset has priority over every other input, including in mid-CFG and with a held packet; the held packet is discarded.

Latency and throughput:
- A packet accepted at edge t appears on bus_data/bus_tag after edge t. It can fire in that same cycle, giving 1-cycle latency.
- Sustained throughput is 1 packet/cycle while all_ready=1.
- bus_data and bus_tag are held unchanged while hold_valid=1 and no fire occurs.

Configuration timing:
- CFG load takes NUM_OF_COLS cfg_valid cycles.
- cfg_loaded rises the cycle after the last write.
- src_ready can first be 1 in that same cycle.

## Configuration
- Macro: GIN_XBUS_CTRL_STALL_CNT_EN.
- **Defined:** adds output stall_cnt, 16 bits.
  - Increments every cycle with hold_valid=1 and all_ready=0.
  - Saturates at 0xFFFF.
  - Cleared by reset and on entry to CFG.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with random inputs. Then:
  - All outputs are 0 and the FSM is in IDLE.
  - src_valid=1 sees src_ready=0.
- **Configuration:** pulse cfg_start, then drive 14 IDs 13..0 with a 1-cycle cfg_valid gap after the 5th.
  - col_id[0]=13 … col_id[13]=0.
  - cfg_loaded rises exactly one cycle after the 14th write.
- **Streaming:** with all bus_ready=1, stream 8 packets (tags 0..7, data 0x100+n) back-to-back.
  - bus_enable is high for 8 consecutive cycles with matching data and tags.
  - src_ready stays 1 throughout.
- **Backpressure:** drop bus_ready[6]=0 for 5 cycles while a packet is held.
  - bus_enable=0 and src_ready=0.
  - bus_data is stable.
  - With STALL_CNT_EN, stall_cnt=5.
  - After bus_ready[6] returns, the packet fires and the next packet follows on the next cycle.
- **Drain-before-reconfigure:** assert cfg_start while a packet is held with bus_ready=0.
  - No new accept occurs.
  - The FSM enters CFG one cycle after the fire, and cfg_loaded falls.
- **Reset mid-CFG:** assert reset after 7 IDs have been written.
  - All col_id=0.
  - The FSM is in IDLE.
  - A following full load starts from col_id[0].

Source files
------------

// File: rtl/gin_xbus_ctrl_if.sv
// GIN X-bus controller signal bundle: column-ID config, upstream packet source and X-bus side.
// The slave modport is the controller's view; master is the surrounding environment.
interface gin_xbus_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned COL_TAG_WIDTH = 4,
    parameter int unsigned NUM_OF_COLS   = 14
);
    logic                     cfg_start;
    logic                     cfg_valid;
    logic [COL_TAG_WIDTH-1:0] cfg_id;
    logic                     cfg_loaded;
    logic [COL_TAG_WIDTH-1:0] col_id [NUM_OF_COLS];
    logic [DATA_WIDTH-1:0]    src_data;
    logic [COL_TAG_WIDTH-1:0] src_tag;
    logic                     src_valid;
    logic                     src_ready;
    logic [DATA_WIDTH-1:0]    bus_data;
    logic [COL_TAG_WIDTH-1:0] bus_tag;
    logic                     bus_enable;
    logic [NUM_OF_COLS-1:0]   bus_ready;

    modport slave (
        input  cfg_start, cfg_valid, cfg_id, src_data, src_tag, src_valid, bus_ready,
        output cfg_loaded, col_id, src_ready, bus_data, bus_tag, bus_enable
    );

    modport master (
        output cfg_start, cfg_valid, cfg_id, src_data, src_tag, src_valid, bus_ready,
        input  cfg_loaded, col_id, src_ready, bus_data, bus_tag, bus_enable
    );
endinterface

// File: rtl/gin_xbus_ctrl.sv
// GIN X-bus controller: loads per-column IDs, then issues tagged packets when all columns are ready.
// Optional GIN_XBUS_CTRL_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module gin_xbus_ctrl #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned COL_TAG_WIDTH = 4,
    parameter int unsigned NUM_OF_COLS   = 14
) (
    input  logic               clk,
    input  logic               reset,
    gin_xbus_ctrl_if.slave     bus_io
`ifdef GIN_XBUS_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int unsigned IdxW = ($clog2(NUM_OF_COLS) > 4) ? $clog2(NUM_OF_COLS) : 4;

    typedef enum logic [1:0] {StIdle, StCfg, StRun} state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [COL_TAG_WIDTH-1:0] col_id_q [NUM_OF_COLS];
    logic [COL_TAG_WIDTH-1:0] col_id_d [NUM_OF_COLS];
    logic                     hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
    logic [COL_TAG_WIDTH-1:0] hold_tag_q, hold_tag_d;
    logic                     cfg_loaded_q, cfg_loaded_d;

    logic all_ready, fire, src_ready, accept, enter_cfg;

    assign all_ready = &bus_io.bus_ready;
    assign fire      = hold_valid_q & all_ready;
    assign src_ready = (state_q == StRun) & (~hold_valid_q | all_ready) & ~bus_io.cfg_start;
    assign accept    = bus_io.src_valid & src_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        col_id_d     = col_id_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_tag_d   = hold_tag_q;
        cfg_loaded_d = cfg_loaded_q;
        enter_cfg    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.cfg_start) begin
                    state_d   = StCfg;
                    enter_cfg = 1'b1;
                end
            end
            StCfg: begin
                if (bus_io.cfg_start) begin
                    enter_cfg = 1'b1;
                end else if (bus_io.cfg_valid) begin
                    for (int i = 0; i < int'(NUM_OF_COLS); i++) begin
                        if (idx_q == IdxW'(i)) col_id_d[i] = bus_io.cfg_id;
                    end
                    if (idx_q == IdxW'(NUM_OF_COLS - 1)) begin
                        state_d      = StRun;
                        cfg_loaded_d = 1'b1;
                        idx_d        = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = bus_io.src_data;
                    hold_tag_d   = bus_io.src_tag;
                end else if (fire) begin
                    hold_valid_d = 1'b0;
                end
                // A held packet must fire before reconfiguration; accepts are already blocked.
                if (bus_io.cfg_start && (!hold_valid_q || all_ready)) begin
                    state_d   = StCfg;
                    enter_cfg = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (enter_cfg) begin
            idx_d        = '0;
            cfg_loaded_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            col_id_q     <= '{default: '0};
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_tag_q   <= '0;
            cfg_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            col_id_q     <= col_id_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_tag_q   <= hold_tag_d;
            cfg_loaded_q <= cfg_loaded_d;
        end
    end

`ifdef GIN_XBUS_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (enter_cfg) begin
            stall_cnt_d = '0;
        end else if (hold_valid_q && !all_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus_io.cfg_loaded = cfg_loaded_q;
    assign bus_io.col_id     = col_id_q;
    assign bus_io.src_ready  = src_ready;
    assign bus_io.bus_data   = hold_data_q;
    assign bus_io.bus_tag    = hold_tag_q;
    assign bus_io.bus_enable = fire;

endmodule
